mod_counter: RTL and testbench
==============================

# mod_counter

Parametrised modulo-N up/down counter: the general successor to the fixed 3-bit octal counter. It counts 0..MODULUS-1 in either direction under an enable, and either wraps or saturates at the limits. A combinational carry/borrow output lets stages cascade into wider or mixed-radix counters, such as timers, prescalers and BCD digits. It sits in the shared timing/utility layer and is instantiated directly by datapath and control blocks.

## Interface
- MODULUS, 8: count range is 0..MODULUS-1. Legal range is 2..2**WIDTH.
- WIDTH, 3: counter width in bits. Elaboration fails via $error if MODULUS > 2**WIDTH or MODULUS < 2.
- SATURATE, 0: 0 = wrap at the limits; 1 = hold at the limits.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  count enable; one step per cycle while high.
- up_dn  input  1  direction: 1 = up, 0 = down. Sampled only when en=1.
- ld  input  1  synchronous load. Present only with MOD_COUNTER_LOAD_EN.
- ld_val  input  WIDTH  load value. Present only with MOD_COUNTER_LOAD_EN.
- cntr  output  WIDTH  current count, registered.
- cy  output  1  carry/borrow, combinational: en && at terminal value for the current direction.
- at_lim  output  1  registered: count equals the terminal value of the last enabled direction.

## Operation
- Priority per edge: rst > ld > en > hold.
- rst: cntr←0, at_lim←0. cy is forced to 0 while rst=1.
- Up terminal value is MODULUS-1. Down terminal value is 0.
- en=1, not at the terminal value: cntr←cntr±1.
- en=1, at the terminal value, SATURATE=0: wrap. Up goes MODULUS-1→0; down goes 0→MODULUS-1.
- en=1, at the terminal value, SATURATE=1: cntr holds.
- cy = en && !rst && (up_dn ? cntr==MODULUS-1 : cntr==0). It is asserted in both modes. A cascaded stage uses cy as its en.
- at_lim is updated only on cycles where en=1. It is set to 1 when the next count equals the terminal value of the current direction, otherwise 0. It holds while en=0.
- Direction change mid-count takes effect on the same edge. There are no pipeline bubbles.
- Arithmetic is done in WIDTH+1 bits internally, so the step never overflows when MODULUS = 2**WIDTH.

## Timing
- Latency: a change on en, up_dn or ld is visible on cntr one edge later.
- cy has zero latency: it is valid in the same cycle as en and cntr, and depends combinationally on en, up_dn and cntr.
- A cascade of N stages is fully synchronous. The critical path is the N-deep AND chain of cy into en.
- rst asserted mid-count: cntr is 0 after the next edge, regardless of en, up_dn or ld.
- First enabled edge after reset deassertion counts from 0. Down from 0 wraps to MODULUS-1 on that edge (SATURATE=0).
- Power-up without reset: cntr is X until the first rst edge. No initial value is relied on.

## Configuration
- MOD_COUNTER_LOAD_EN defined: ld and ld_val ports exist.
  - ld=1 sets cntr←ld_val if ld_val < MODULUS, else cntr←MODULUS-1 (clamped).
  - A load overrides en. at_lim←0 on a load.
  - cy is 0 in a ld cycle.
- MOD_COUNTER_LOAD_EN undefined: ports are absent and the load path is removed. Behaviour is otherwise identical.

## Structure
- Package mod_counter_pkg holds:
  - enum dir_e {DIR_DN=0, DIR_UP=1}
  - constant function term_val(MODULUS, dir) returning the terminal value.
- Sub-module mod_counter_step is combinational: inputs cntr, up_dn; outputs next value and terminal-hit.
- The top level holds the register, priority logic and load clamp.

## Test plan
- Default params, SATURATE=0: reset, then en=1, up_dn=1 for 10 cycles → cntr 1..7,0,1,2; cy=1 exactly in the cycle cntr=7.
- MODULUS=10, WIDTH=4, down: after reset, en=1, up_dn=0 → cntr 9,8,…,0,9; cy=1 in each cycle cntr=0.
- SATURATE=1, MODULUS=5: count up 6 cycles → cntr 1,2,3,4,4,4; at_lim=1 from the edge reaching 4. Then flip up_dn=0 → cntr 3.
- Cascade: two MODULUS=10 stages, lower stage cy driving upper stage en, 25 enabled up cycles → {hi,lo}=2,5. Upper stage increments only on the 9→0 edges.
- With MOD_COUNTER_LOAD_EN and MODULUS=6: ld=1, ld_val=3 → cntr=3. Then ld_val=7 → cntr=5 (clamped). ld and en both high → load wins.
- rst=1 mid-count at cntr=4 with en=1 → cntr=0 next edge, cy=0 during rst. Releasing rst resumes counting at 1.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// ---------------------------------------------------------------------------
// mod_counter_pkg
// Shared types and helpers for the modulo-N up/down counter.
//   dir_e     : count direction encoding (matches the up_dn port: 1 = up)
//   term_val  : terminal value of a modulo-N counter for a given direction
// ---------------------------------------------------------------------------
package mod_counter_pkg;

    typedef enum logic {
        DIR_DN = 1'b0,
        DIR_UP = 1'b1
    } dir_e;

    // Up terminal is the top of the range, down terminal is zero.
    function automatic int unsigned term_val(input int unsigned modulus, input dir_e dir);
        return (dir == DIR_UP) ? (modulus - 1) : 0;
    endfunction

endpackage

// File: rtl/mod_counter_step.sv
// ---------------------------------------------------------------------------
// mod_counter_step
// Combinational single-step of a modulo-N counter with wrap-around.
// Ports:
//   i_cntr     : current count (0..MODULUS-1)
//   i_up_dn    : direction, 1 = up, 0 = down
//   o_nxt      : count after one step, wrapped into 0..MODULUS-1
//   o_term_hit : current count is the terminal value for this direction
// ---------------------------------------------------------------------------
module mod_counter_step
    import mod_counter_pkg::*;
#(
    parameter int MODULUS = 8,
    parameter int WIDTH   = 3
) (
    input  logic [WIDTH-1:0] i_cntr,
    input  logic             i_up_dn,
    output logic [WIDTH-1:0] o_nxt,
    output logic             o_term_hit
);

    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   ONE_EXT = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] WRAP_UP = WIDTH'(term_val(MODULUS, DIR_UP));
    localparam logic [WIDTH-1:0] WRAP_DN = WIDTH'(term_val(MODULUS, DIR_DN));

    dir_e             w_dir;
    logic [WIDTH:0]   w_ext;
    logic [WIDTH:0]   w_inc;
    logic [WIDTH:0]   w_dec;
    logic             w_up_hit;
    logic             w_dn_hit;

    assign w_dir = dir_e'(i_up_dn);

    // One extra bit so the increment from 2**WIDTH-1 cannot overflow and the
    // decrement from 0 shows up as a borrow in the top bit.
    assign w_ext = {1'b0, i_cntr};
    assign w_inc = w_ext + ONE_EXT;
    assign w_dec = w_ext - ONE_EXT;

    // Up terminal: the increment would reach MODULUS. Down terminal: borrow.
    assign w_up_hit = (w_inc == MOD_EXT);
    assign w_dn_hit = w_dec[WIDTH];

    assign o_term_hit = (w_dir == DIR_UP) ? w_up_hit : w_dn_hit;

    always_comb begin
        o_nxt = i_cntr;
        if (w_dir == DIR_UP) begin
            o_nxt = w_up_hit ? WRAP_DN : w_inc[WIDTH-1:0];
        end else begin
            o_nxt = w_dn_hit ? WRAP_UP : w_dec[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mod_counter.sv
// ---------------------------------------------------------------------------
// mod_counter
// Parametrised modulo-N up/down counter with wrap or saturate at the limits
// and a combinational carry/borrow for cascading stages.
// Optional feature macro: MOD_COUNTER_LOAD_EN adds a synchronous load port.
// Parameters:
//   MODULUS  : count range 0..MODULUS-1 (2..2**WIDTH)
//   WIDTH    : counter width in bits
//   SATURATE : 0 = wrap at the limits, 1 = hold at the limits
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   en      : count enable, one step per cycle
//   up_dn   : direction, 1 = up, 0 = down
//   ld      : synchronous load (MOD_COUNTER_LOAD_EN only)
//   ld_val  : load value, clamped to MODULUS-1 (MOD_COUNTER_LOAD_EN only)
//   cntr    : registered count
//   cy      : combinational carry/borrow, feeds the next stage's en
//   at_lim  : registered, count sits at the terminal of the last enabled
//             direction
// ---------------------------------------------------------------------------
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int MODULUS  = 8,
    parameter int WIDTH    = 3,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
`ifdef MOD_COUNTER_LOAD_EN
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
`endif
    output logic [WIDTH-1:0] cntr,
    output logic             cy,
    output logic             at_lim
);

    localparam logic [WIDTH-1:0] TERM_UP = WIDTH'(term_val(MODULUS, DIR_UP));
    localparam logic [WIDTH-1:0] TERM_DN = WIDTH'(term_val(MODULUS, DIR_DN));

    generate
        if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_param
            $error("mod_counter: MODULUS %0d outside 2..2**WIDTH (WIDTH=%0d)", MODULUS, WIDTH);
        end
    endgenerate

    logic [WIDTH-1:0] r_cntr;
    logic             r_at_lim;
    logic [WIDTH-1:0] w_step_nxt;
    logic             w_term_hit;
    logic [WIDTH-1:0] w_en_nxt;
    logic             w_en_lim;
    logic             w_ld_blk;

    mod_counter_step #(
        .MODULUS (MODULUS),
        .WIDTH   (WIDTH)
    ) u_step (
        .i_cntr     (r_cntr),
        .i_up_dn    (up_dn),
        .o_nxt      (w_step_nxt),
        .o_term_hit (w_term_hit)
    );

    // Saturating build holds at the terminal instead of taking the wrap.
    assign w_en_nxt = (w_term_hit && (SATURATE != 0)) ? r_cntr : w_step_nxt;
    assign w_en_lim = up_dn ? (w_en_nxt == TERM_UP) : (w_en_nxt == TERM_DN);

`ifdef MOD_COUNTER_LOAD_EN
    // Out-of-range load values land on the top of the range.
    function automatic logic [WIDTH-1:0] clamp_ld(input logic [WIDTH-1:0] v);
        if ({1'b0, v} < (WIDTH+1)'(MODULUS)) begin
            return v;
        end
        return TERM_UP;
    endfunction

    // A load cycle never counts, so it must not ripple into the next stage.
    assign w_ld_blk = ld;
`else
    assign w_ld_blk = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cntr   <= '0;
            r_at_lim <= 1'b0;
        end
`ifdef MOD_COUNTER_LOAD_EN
        else if (ld) begin
            r_cntr   <= clamp_ld(ld_val);
            r_at_lim <= 1'b0;
        end
`endif
        else if (en) begin
            r_cntr   <= w_en_nxt;
            r_at_lim <= w_en_lim;
        end
    end

    assign cntr   = r_cntr;
    assign at_lim = r_at_lim;
    assign cy     = en && !rst && !w_ld_blk && w_term_hit;

endmodule

// File: tb/tb_mod_counter.sv
module tb_mod_counter;

    // Instance map: 0 = default (M8), 1 = M10 down, 2 = M5 saturating,
    // 3 = cascade low digit, 4 = cascade high digit, 5 = M6 load stage
    localparam int M_P   [6] = '{8, 10, 5, 10, 10, 6};
    localparam bit SAT_P [6] = '{0, 0, 1, 0, 0, 0};
    localparam int A_SEQ [10] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
    localparam int B_SEQ [11] = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 9};
    localparam int C_SEQ [6]  = '{1, 2, 3, 4, 4, 4};

    logic       clk;
    logic       rst;
    logic [5:0] en_v;
    logic [5:0] up_v;
    logic       ld_e;
    logic [2:0] ld_val_e;

    logic [2:0] cnt_a, cnt_c, cnt_e;
    logic [3:0] cnt_b, cnt_lo, cnt_hi;
    logic       cy_a, cy_b, cy_c, cy_lo, cy_hi, cy_e;
    logic       lim_a, lim_b, lim_c, lim_lo, lim_hi, lim_e;
    wire        hi_en = cy_lo & en_v[4];

    wire [3:0] cnt_v [6];
    wire [5:0] cy_v  = {cy_e, cy_hi, cy_lo, cy_c, cy_b, cy_a};
    wire [5:0] lim_v = {lim_e, lim_hi, lim_lo, lim_c, lim_b, lim_a};
    assign cnt_v[0] = {1'b0, cnt_a};
    assign cnt_v[1] = cnt_b;
    assign cnt_v[2] = {1'b0, cnt_c};
    assign cnt_v[3] = cnt_lo;
    assign cnt_v[4] = cnt_hi;
    assign cnt_v[5] = {1'b0, cnt_e};

    int total = 0;
    int bad   = 0;

    mod_counter u_a (.clk(clk), .rst(rst), .en(en_v[0]), .up_dn(up_v[0]),
`ifdef MOD_COUNTER_LOAD_EN
        .ld(1'b0), .ld_val(3'd0),
`endif
        .cntr(cnt_a), .cy(cy_a), .at_lim(lim_a));

    mod_counter #(.MODULUS(10), .WIDTH(4), .SATURATE(0)) u_b (.clk(clk), .rst(rst), .en(en_v[1]), .up_dn(up_v[1]),
`ifdef MOD_COUNTER_LOAD_EN
        .ld(1'b0), .ld_val(4'd0),
`endif
        .cntr(cnt_b), .cy(cy_b), .at_lim(lim_b));

    mod_counter #(.MODULUS(5), .WIDTH(3), .SATURATE(1)) u_c (.clk(clk), .rst(rst), .en(en_v[2]), .up_dn(up_v[2]),
`ifdef MOD_COUNTER_LOAD_EN
        .ld(1'b0), .ld_val(3'd0),
`endif
        .cntr(cnt_c), .cy(cy_c), .at_lim(lim_c));

    mod_counter #(.MODULUS(10), .WIDTH(4), .SATURATE(0)) u_lo (.clk(clk), .rst(rst), .en(en_v[3]), .up_dn(up_v[3]),
`ifdef MOD_COUNTER_LOAD_EN
        .ld(1'b0), .ld_val(4'd0),
`endif
        .cntr(cnt_lo), .cy(cy_lo), .at_lim(lim_lo));

    mod_counter #(.MODULUS(10), .WIDTH(4), .SATURATE(0)) u_hi (.clk(clk), .rst(rst), .en(hi_en), .up_dn(up_v[4]),
`ifdef MOD_COUNTER_LOAD_EN
        .ld(1'b0), .ld_val(4'd0),
`endif
        .cntr(cnt_hi), .cy(cy_hi), .at_lim(lim_hi));

    mod_counter #(.MODULUS(6), .WIDTH(3), .SATURATE(0)) u_e (.clk(clk), .rst(rst), .en(en_v[5]), .up_dn(up_v[5]),
`ifdef MOD_COUNTER_LOAD_EN
        .ld(ld_e), .ld_val(ld_val_e),
`endif
        .cntr(cnt_e), .cy(cy_e), .at_lim(lim_e));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_cnt [6];
    bit m_lim [6];
    bit m_cy  [6];
    bit m_en  [6];
    bit m_known = 1'b0;

    // Plain modular arithmetic; saturating counters simply refuse to leave
    // the range.
    function automatic int m_next(input int c, input int md, input bit sat, input bit u);
        int raw;
        raw = u ? c + 1 : c - 1;
        if (sat) begin
            if (raw < 0) return 0;
            if (raw > md - 1) return md - 1;
            return raw;
        end
        return (raw + md) % md;
    endfunction

    function automatic bit m_ld(input int i);
        return (i == 5) && (ld_e === 1'b1);
    endfunction

    task automatic calc_cy();
        for (int i = 0; i < 6; i++) begin
            m_en[i] = (i == 4) ? (m_cy[3] && en_v[4]) : en_v[i];
            m_cy[i] = m_en[i] && !rst && !m_ld(i) &&
                      (m_cnt[i] == (up_v[i] ? M_P[i] - 1 : 0));
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) begin
                m_cnt[i] = 0;
                m_lim[i] = 1'b0;
            end
            m_known = 1'b1;
        end else if (m_known) begin
            calc_cy();
            for (int i = 0; i < 6; i++) begin
                if (m_ld(i)) begin
                    m_cnt[i] = (int'(ld_val_e) < M_P[i]) ? int'(ld_val_e) : M_P[i] - 1;
                    m_lim[i] = 1'b0;
                end else if (m_en[i]) begin
                    m_cnt[i] = m_next(m_cnt[i], M_P[i], SAT_P[i], up_v[i]);
                    m_lim[i] = (m_cnt[i] == (up_v[i] ? M_P[i] - 1 : 0));
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_x(input string name, input logic [3:0] act, input int exp);
        total++;
        if ($isunknown(act) || int'(act) != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every instance against the model on every falling edge.
    always @(negedge clk) begin
        if (m_known) begin
            calc_cy();
            for (int i = 0; i < 6; i++) begin
                chk_x($sformatf("model_cntr%0d", i), cnt_v[i], m_cnt[i]);
                chk_x($sformatf("model_cy%0d", i), {3'b0, cy_v[i]}, int'(m_cy[i]));
                chk_x($sformatf("model_lim%0d", i), {3'b0, lim_v[i]}, int'(m_lim[i]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst      = 1'b1;
        en_v     = 6'b111111;
        up_v     = 6'b000000;
        ld_e     = 1'b0;
        ld_val_e = 3'd0;
        tick();
        tick();
        // Down terminal (0) with en=1: cy must still be low under reset.
        chk("rst_cntr", int'(cnt_a), 0);
        chk("rst_lim", int'(lim_a), 0);
        chk("rst_cy", int'(cy_a), 0);

        rst  = 1'b0;
        en_v = 6'b011111;
        up_v = 6'b011101;
        for (int k = 1; k <= 25; k++) begin
            tick();
            if (k <= 10) begin
                chk("a_up_seq", int'(cnt_a), A_SEQ[k-1]);
                chk("a_up_cy", int'(cy_a), (k == 7) ? 1 : 0);
            end
            if (k == 10) en_v[0] = 1'b0;
            if (k <= 11) begin
                chk("b_dn_seq", int'(cnt_b), B_SEQ[k-1]);
                chk("b_dn_cy", int'(cy_b), (k == 10) ? 1 : 0);
            end
            if (k == 11) en_v[1] = 1'b0;
            if (k <= 6) begin
                chk("c_sat_seq", int'(cnt_c), C_SEQ[k-1]);
                chk("c_sat_lim", int'(lim_c), (k >= 4) ? 1 : 0);
            end
            if (k == 6) up_v[2] = 1'b0;
            if (k == 7) begin
                chk("c_flip_cntr", int'(cnt_c), 3);
                chk("c_flip_lim", int'(lim_c), 0);
                en_v[2] = 1'b0;
            end
            if (k == 9) begin
                chk("casc9_lo", int'(cnt_lo), 9);
                chk("casc9_hi", int'(cnt_hi), 0);
            end
            if (k == 10) begin
                chk("casc10_lo", int'(cnt_lo), 0);
                chk("casc10_hi", int'(cnt_hi), 1);
            end
        end
        chk("casc25_hi", int'(cnt_hi), 2);
        chk("casc25_lo", int'(cnt_lo), 5);
        en_v[3] = 1'b0;

        // Mid-count reset on the default stage.
        en_v[0] = 1'b1;
        up_v[0] = 1'b1;
        tick();
        tick();
        chk("a_pre_rst", int'(cnt_a), 4);
        rst = 1'b1;
        #1;
        chk("a_cy_in_rst", int'(cy_a), 0);
        tick();
        chk("a_after_rst", int'(cnt_a), 0);
        rst = 1'b0;
        tick();
        chk("a_resume1", int'(cnt_a), 1);
        tick();
        chk("a_resume2", int'(cnt_a), 2);
        en_v[0] = 1'b0;

`ifdef MOD_COUNTER_LOAD_EN
        ld_e     = 1'b1;
        ld_val_e = 3'd3;
        tick();
        chk("ld_3", int'(cnt_e), 3);
        chk("ld_lim", int'(lim_e), 0);
        ld_val_e = 3'd7;
        tick();
        chk("ld_clamp", int'(cnt_e), 5);
        ld_val_e = 3'd2;
        en_v[5]  = 1'b1;
        up_v[5]  = 1'b1;
        #1;
        chk("ld_cy_blk", int'(cy_e), 0);
        tick();
        chk("ld_wins", int'(cnt_e), 2);
        ld_e = 1'b0;
        tick();
        chk("ld_then_cnt", int'(cnt_e), 3);
        en_v[5] = 1'b0;
        tick();
`else
        en_v[5] = 1'b1;
        up_v[5] = 1'b0;
        tick();
        chk("e_dn_wrap", int'(cnt_e), 5);
        chk("e_dn_lim", int'(lim_e), 0);
        for (int k = 0; k < 5; k++) tick();
        chk("e_dn_zero", int'(cnt_e), 0);
        chk("e_dn_lim0", int'(lim_e), 1);
        en_v[5] = 1'b0;
        tick();
        chk("e_hold_lim", int'(lim_e), 1);
`endif
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
